// File: rtl/sparc_ffu_frf_arb_pkg.sv
// Shared types and constants for the FFU register-file port arbiter.
// The FRF port is 78 bits wide: two 39-bit halves, each with its own write enable.
package frf_arb_pkg;
    localparam int FRF_ADDR_W = 7;
    localparam int FRF_HALF_W = 39;
    localparam int FRF_DATA_W = 2 * FRF_HALF_W;
    localparam int RD_LAT     = 2;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LD   = 2'd1,
        SRC_FPU  = 2'd2,
        SRC_RD   = 2'd3
    } src_e;

    typedef struct packed {
        logic [FRF_ADDR_W-1:0] addr;
        logic [1:0]            wen;
        logic [FRF_DATA_W-1:0] data;
    } ld_ent_t;
endpackage

// File: rtl/sparc_ffu_frf_arb_if.sv
// Requester and FRF-side signals of the arbiter.
// The master modport is the environment; the slave modport is the arbiter.
interface sparc_ffu_frf_arb_if #(parameter int TAG_W = 2);
    import frf_arb_pkg::*;

    logic                  lsu_ld_vld;
    logic [FRF_ADDR_W-1:0] lsu_ld_addr;
    logic [1:0]            lsu_ld_wen;
    logic [FRF_DATA_W-1:0] lsu_ld_data;
    logic                  ld_buf_full;

    logic                  fpu_wr_req;
    logic [FRF_ADDR_W-1:0] fpu_wr_addr;
    logic [1:0]            fpu_wr_wen;
    logic [FRF_DATA_W-1:0] fpu_wr_data;
    logic                  fpu_wr_gnt;

    logic                  rd_req;
    logic [FRF_ADDR_W-1:0] rd_addr;
    logic [TAG_W-1:0]      rd_tag;
    logic                  rd_gnt;

    logic [FRF_DATA_W-1:0] frf_dp_data;
    logic                  rd_rsp_vld;
    logic [TAG_W-1:0]      rd_rsp_tag;
    logic [FRF_DATA_W-1:0] rd_rsp_data;

    logic [1:0]            ctl_frf_wen;
    logic                  ctl_frf_ren;
    logic [FRF_ADDR_W-1:0] ctl_frf_addr;
    logic [FRF_DATA_W-1:0] dp_frf_data;

    modport master (
        output lsu_ld_vld, lsu_ld_addr, lsu_ld_wen, lsu_ld_data,
        output fpu_wr_req, fpu_wr_addr, fpu_wr_wen, fpu_wr_data,
        output rd_req, rd_addr, rd_tag, frf_dp_data,
        input  ld_buf_full, fpu_wr_gnt, rd_gnt,
        input  rd_rsp_vld, rd_rsp_tag, rd_rsp_data,
        input  ctl_frf_wen, ctl_frf_ren, ctl_frf_addr, dp_frf_data
    );

    modport slave (
        input  lsu_ld_vld, lsu_ld_addr, lsu_ld_wen, lsu_ld_data,
        input  fpu_wr_req, fpu_wr_addr, fpu_wr_wen, fpu_wr_data,
        input  rd_req, rd_addr, rd_tag, frf_dp_data,
        output ld_buf_full, fpu_wr_gnt, rd_gnt,
        output rd_rsp_vld, rd_rsp_tag, rd_rsp_data,
        output ctl_frf_wen, ctl_frf_ren, ctl_frf_addr, dp_frf_data
    );
endinterface

// File: rtl/sparc_ffu_frf_ldq.sv
// Small FIFO holding LSU load-return writes that lost the FRF port.
// A push while full is dropped, and a pop while empty is ignored.
module sparc_ffu_frf_ldq
    import frf_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          rclk,
    input  logic          arst_l,
    input  logic          push,
    input  logic          pop,
    input  ld_ent_t       din,
    output ld_ent_t       head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    ld_ent_t       mem_q [DEPTH];
    ld_ent_t       mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: an entry is only read after it has been written.
    always_ff @(posedge rclk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/sparc_ffu_frf_arb.sv
// Arbiter for the single FFU register-file R/W port, shared by three sources.
// Loads win over FPU writes and reads; FPU writes and reads alternate round-robin.
module sparc_ffu_frf_arb
    import frf_arb_pkg::*;
#(
    parameter int LDQ_DEPTH  = 2,
    parameter int STARVE_MAX = 4,
    parameter int TAG_W      = 2
) (
    input  logic rclk,
    input  logic arst_l,
    sparc_ffu_frf_arb_if.slave bus
);
    localparam int CW = $clog2(LDQ_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    src_e                        src;
    ld_ent_t                     ld_in, ld_sel, q_head;
    logic [CW-1:0]               q_count;
    logic                        q_full, q_empty, push, pop;
    logic                        req_pend, ld_avail, override;
    logic [SW-1:0]               starve_q, starve_d;
    logic                        rr_q, rr_d;
    logic [RD_LAT:1]             vld_pipe_q, vld_pipe_d;
    logic [RD_LAT:1][TAG_W-1:0]  tag_pipe_q, tag_pipe_d;

    assign ld_in = '{addr: bus.lsu_ld_addr, wen: bus.lsu_ld_wen, data: bus.lsu_ld_data};

    sparc_ffu_frf_ldq #(.DEPTH(LDQ_DEPTH)) u_ldq (
        .rclk  (rclk),
        .arst_l(arst_l),
        .push  (push),
        .pop   (pop),
        .din   (ld_in),
        .head  (q_head),
        .count (q_count),
        .full  (q_full),
        .empty (q_empty)
    );

    // Override lets a starved FPU write or read take the port, but never when the buffer is full.
    always_comb begin
        src      = SRC_NONE;
        pop      = 1'b0;
        ld_sel   = '0;
        req_pend = bus.fpu_wr_req || bus.rd_req;
        ld_avail = !q_empty || bus.lsu_ld_vld;
        override = req_pend && (starve_q == SW'(STARVE_MAX)) && (q_count < CW'(LDQ_DEPTH));
        if (!arst_l) begin
            src = SRC_NONE;
        end else if (ld_avail && !override) begin
            src = SRC_LD;
            if (!q_empty) begin
                pop    = 1'b1;
                ld_sel = q_head;
            end else begin
                ld_sel = ld_in;
            end
        end else if (req_pend) begin
            src = (bus.rd_req && (!bus.fpu_wr_req || !rr_q)) ? SRC_RD : SRC_FPU;
        end
        push = arst_l && bus.lsu_ld_vld && !q_full && !(src == SRC_LD && q_empty);
    end

    always_comb begin
        bus.ctl_frf_wen  = 2'b00;
        bus.ctl_frf_ren  = 1'b0;
        bus.ctl_frf_addr = '0;
        bus.dp_frf_data  = '0;
        case (src)
            SRC_LD: begin
                bus.ctl_frf_wen  = ld_sel.wen;
                bus.ctl_frf_addr = ld_sel.addr;
                bus.dp_frf_data  = ld_sel.data;
            end
            SRC_FPU: begin
                bus.ctl_frf_wen  = bus.fpu_wr_wen;
                bus.ctl_frf_addr = bus.fpu_wr_addr;
                bus.dp_frf_data  = bus.fpu_wr_data;
            end
            SRC_RD: begin
                bus.ctl_frf_ren  = 1'b1;
                bus.ctl_frf_addr = bus.rd_addr;
            end
            default: ;
        endcase
    end

    assign bus.fpu_wr_gnt  = (src == SRC_FPU);
    assign bus.rd_gnt      = (src == SRC_RD);
    assign bus.ld_buf_full = q_full;
    assign bus.rd_rsp_vld  = vld_pipe_q[RD_LAT];
    assign bus.rd_rsp_tag  = tag_pipe_q[RD_LAT];
    assign bus.rd_rsp_data = bus.frf_dp_data;

    always_comb begin
        starve_d = starve_q;
        rr_d     = rr_q;
        if (src == SRC_FPU || src == SRC_RD) begin
            starve_d = '0;
            rr_d     = (src == SRC_RD);
        end else if (req_pend && src == SRC_LD && starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
        vld_pipe_d    = {vld_pipe_q[RD_LAT-1:1], bus.rd_gnt};
        tag_pipe_d[1] = bus.rd_gnt ? bus.rd_tag : '0;
        for (int i = 2; i <= RD_LAT; i++) tag_pipe_d[i] = tag_pipe_q[i-1];
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            starve_q   <= '0;
            rr_q       <= 1'b0;
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
        end else begin
            starve_q   <= starve_d;
            rr_q       <= rr_d;
            vld_pipe_q <= vld_pipe_d;
            tag_pipe_q <= tag_pipe_d;
        end
    end

    ld_no_push_when_full: assert property (@(posedge rclk) disable iff (!arst_l)
        !(bus.lsu_ld_vld && q_full));
endmodule

// File: tb/tb_sparc_ffu_frf_arb.sv
// Directed per-cycle vectors for the FRF port arbiter.
// A hand-written sequence at the end checks that a reset drops an in-flight read.
module tb_sparc_ffu_frf_arb;
    logic rclk = 1'b0;
    logic arst_l = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   vi = 0;

    always #5 rclk = ~rclk;

    sparc_ffu_frf_arb_if #(.TAG_W(2)) bus ();

    sparc_ffu_frf_arb #(.LDQ_DEPTH(2), .STARVE_MAX(4), .TAG_W(2)) dut (
        .rclk  (rclk),
        .arst_l(arst_l),
        .bus   (bus)
    );

    typedef struct {
        bit         new_sc;
        bit         ld;  logic [6:0] la; logic [1:0] lw;
        bit         fq;  logic [6:0] fa; logic [1:0] fw;
        bit         rq;  logic [6:0] ra; logic [1:0] rt;
        logic [1:0] e_wen; bit e_ren; logic [6:0] e_addr; int e_dsel;
        bit         e_fg; bit e_rg; bit e_full; bit e_rv; logic [1:0] e_rt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [77:0] ld_d(input logic [6:0] a);
        return {7'h55, 64'h0, a};
    endfunction

    function automatic logic [77:0] fpu_d(input logic [6:0] a);
        return {7'h2A, 64'h1234_5678_9ABC_DEF0, a};
    endfunction

    task automatic add(input bit ns,
                       input bit ld, input logic [6:0] la, input logic [1:0] lw,
                       input bit fq, input logic [6:0] fa, input logic [1:0] fw,
                       input bit rq, input logic [6:0] ra, input logic [1:0] rt,
                       input logic [1:0] ew, input bit er, input logic [6:0] ea, input int ed,
                       input bit efg, input bit erg, input bit efu, input bit erv, input logic [1:0] ert);
        vec_t v;
        v = '{ns, ld, la, lw, fq, fa, fw, rq, ra, rt, ew, er, ea, ed, efg, erg, efu, erv, ert};
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d got=%h want=%h", nm, vi, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.lsu_ld_vld = 0; bus.lsu_ld_addr = '0; bus.lsu_ld_wen = '0; bus.lsu_ld_data = '0;
        bus.fpu_wr_req = 0; bus.fpu_wr_addr = '0; bus.fpu_wr_wen = '0; bus.fpu_wr_data = '0;
        bus.rd_req = 0; bus.rd_addr = '0; bus.rd_tag = '0;
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({bus.ctl_frf_wen, bus.ctl_frf_ren, bus.ctl_frf_addr, bus.dp_frf_data,
                     bus.fpu_wr_gnt, bus.rd_gnt, bus.ld_buf_full, bus.rd_rsp_vld, bus.rd_rsp_tag});
    endfunction

    task automatic do_reset();
        @(negedge rclk);
        arst_l = 0;
        idle_inputs();
        #2 chk("reset_outs", all_outs(), '0);
        @(negedge rclk);
        @(negedge rclk);
        arst_l = 1;
    endtask

    initial begin
        logic [77:0] edata;
        idle_inputs();
        bus.frf_dp_data = '0;

        // Single read: grant now, response two cycles later.
        add(1, 0,7'h00,2'b00, 0,7'h00,2'b00, 1,7'h15,2'd1, 2'b00,1,7'h15,0, 0,1,0,0,2'd0);
        add(0, 0,7'h00,2'b00, 0,7'h00,2'b00, 0,7'h00,2'd0, 2'b00,0,7'h00,0, 0,0,0,0,2'd0);
        add(0, 0,7'h00,2'b00, 0,7'h00,2'b00, 0,7'h00,2'd0, 2'b00,0,7'h00,0, 0,0,0,1,2'd1);
        add(0, 0,7'h00,2'b00, 0,7'h00,2'b00, 0,7'h00,2'd0, 2'b00,0,7'h00,0, 0,0,0,0,2'd0);
        // FPU write and read together alternate rd, fpu, rd, fpu; second FPU write is a wen=00 no-op.
        add(1, 0,7'h00,2'b00, 1,7'h20,2'b11, 1,7'h30,2'd2, 2'b00,1,7'h30,0, 0,1,0,0,2'd0);
        add(0, 0,7'h00,2'b00, 1,7'h20,2'b11, 1,7'h30,2'd2, 2'b11,0,7'h20,2, 1,0,0,0,2'd0);
        add(0, 0,7'h00,2'b00, 1,7'h21,2'b00, 1,7'h30,2'd2, 2'b00,1,7'h30,0, 0,1,0,1,2'd2);
        add(0, 0,7'h00,2'b00, 1,7'h21,2'b00, 0,7'h00,2'd0, 2'b00,0,7'h21,2, 1,0,0,0,2'd0);
        add(0, 0,7'h00,2'b00, 0,7'h00,2'b00, 0,7'h00,2'd0, 2'b00,0,7'h00,0, 0,0,0,1,2'd2);
        // Load bypass beats a concurrent read; read goes next cycle.
        add(1, 1,7'h05,2'b10, 0,7'h00,2'b00, 1,7'h31,2'd3, 2'b10,0,7'h05,1, 0,0,0,0,2'd0);
        add(0, 0,7'h00,2'b00, 0,7'h00,2'b00, 1,7'h31,2'd3, 2'b00,1,7'h31,0, 0,1,0,0,2'd0);
        add(0, 0,7'h00,2'b00, 0,7'h00,2'b00, 0,7'h00,2'd0, 2'b00,0,7'h00,0, 0,0,0,0,2'd0);
        add(0, 0,7'h00,2'b00, 0,7'h00,2'b00, 0,7'h00,2'd0, 2'b00,0,7'h00,0, 0,0,0,1,2'd3);
        // Continuous loads starve a held read until the override at cycle 4, then fill the buffer.
        for (int c = 0; c < 4; c++)
            add(c == 0, 1,7'(c),2'b11, 0,7'h00,2'b00, 1,7'h40,2'd0, 2'b11,0,7'(c),1, 0,0,0,0,2'd0);
        add(0, 1,7'h04,2'b11, 0,7'h00,2'b00, 1,7'h40,2'd0, 2'b00,1,7'h40,0, 0,1,0,0,2'd0);
        add(0, 1,7'h05,2'b11, 0,7'h00,2'b00, 1,7'h40,2'd2, 2'b11,0,7'h04,1, 0,0,0,0,2'd0);
        add(0, 1,7'h06,2'b11, 0,7'h00,2'b00, 1,7'h40,2'd2, 2'b11,0,7'h05,1, 0,0,0,1,2'd0);
        add(0, 1,7'h07,2'b11, 0,7'h00,2'b00, 1,7'h40,2'd2, 2'b11,0,7'h06,1, 0,0,0,0,2'd0);
        add(0, 1,7'h08,2'b11, 0,7'h00,2'b00, 1,7'h40,2'd2, 2'b11,0,7'h07,1, 0,0,0,0,2'd0);
        add(0, 1,7'h09,2'b11, 0,7'h00,2'b00, 1,7'h40,2'd2, 2'b00,1,7'h40,0, 0,1,0,0,2'd0);
        add(0, 0,7'h00,2'b00, 0,7'h00,2'b00, 1,7'h40,2'd2, 2'b11,0,7'h08,1, 0,0,1,0,2'd0);
        add(0, 0,7'h00,2'b00, 0,7'h00,2'b00, 1,7'h40,2'd2, 2'b11,0,7'h09,1, 0,0,0,1,2'd2);
        add(0, 0,7'h00,2'b00, 0,7'h00,2'b00, 1,7'h40,2'd2, 2'b00,1,7'h40,0, 0,1,0,0,2'd0);
        add(0, 0,7'h00,2'b00, 0,7'h00,2'b00, 0,7'h00,2'd0, 2'b00,0,7'h00,0, 0,0,0,0,2'd0);
        add(0, 0,7'h00,2'b00, 0,7'h00,2'b00, 0,7'h00,2'd0, 2'b00,0,7'h00,0, 0,0,0,1,2'd2);

        for (int i = 0; i < vecs.size(); i++) begin
            vi = i;
            if (vecs[i].new_sc) do_reset();
            @(posedge rclk);
            #1;
            bus.lsu_ld_vld  = vecs[i].ld;
            bus.lsu_ld_addr = vecs[i].la;
            bus.lsu_ld_wen  = vecs[i].lw;
            bus.lsu_ld_data = ld_d(vecs[i].la);
            bus.fpu_wr_req  = vecs[i].fq;
            bus.fpu_wr_addr = vecs[i].fa;
            bus.fpu_wr_wen  = vecs[i].fw;
            bus.fpu_wr_data = fpu_d(vecs[i].fa);
            bus.rd_req      = vecs[i].rq;
            bus.rd_addr     = vecs[i].ra;
            bus.rd_tag      = vecs[i].rt;
            bus.frf_dp_data = {14'($urandom), 32'($urandom), 32'($urandom)};
            @(negedge rclk);
            edata = (vecs[i].e_dsel == 1) ? ld_d(vecs[i].e_addr) :
                    (vecs[i].e_dsel == 2) ? fpu_d(vecs[i].e_addr) : '0;
            chk("frf_ctl", 128'({bus.ctl_frf_wen, bus.ctl_frf_ren, bus.ctl_frf_addr, bus.dp_frf_data}),
                128'({vecs[i].e_wen, vecs[i].e_ren, vecs[i].e_addr, edata}));
            chk("gnt_rsp", 128'({bus.fpu_wr_gnt, bus.rd_gnt, bus.ld_buf_full, bus.rd_rsp_vld, bus.rd_rsp_tag}),
                128'({vecs[i].e_fg, vecs[i].e_rg, vecs[i].e_full, vecs[i].e_rv, vecs[i].e_rt}));
            chk("ren_wen_excl", 128'(bus.ctl_frf_ren && (bus.ctl_frf_wen != 2'b00)), '0);
            if (vecs[i].e_rv) chk("rsp_data", 128'(bus.rd_rsp_data), 128'(bus.frf_dp_data));
        end

        // Read granted, then reset at G+1 with requests still asserted.
        vi = 1000;
        do_reset();
        @(posedge rclk);
        #1;
        bus.rd_req = 1; bus.rd_addr = 7'h15; bus.rd_tag = 2'd3;
        @(negedge rclk);
        chk("pre_rst_gnt", 128'({bus.rd_gnt, bus.ctl_frf_ren, bus.ctl_frf_addr}), 128'({1'b1, 1'b1, 7'h15}));
        @(posedge rclk);
        #1;
        bus.rd_req = 1; bus.lsu_ld_vld = 1; bus.lsu_ld_addr = 7'h11; bus.lsu_ld_wen = 2'b11;
        #1 arst_l = 0;
        @(negedge rclk);
        chk("in_rst_outs", all_outs(), '0);
        @(posedge rclk);
        #1;
        chk("in_rst_outs2", all_outs(), '0);
        idle_inputs();
        @(negedge rclk);
        arst_l = 1;
        for (int c = 0; c < 3; c++) begin
            vi = 1001 + c;
            @(negedge rclk);
            chk("post_rst_outs", all_outs(), '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end
endmodule

// File: doc/sparc_ffu_frf_arb.md
Name: sparc_ffu_frf_arb

Overview:
- Port arbiter and sequencer for the FFU floating-point register file's single 78-bit R/W port.
- Shares that port between three requesters: LSU load-return writes (no backpressure, buffered), FPU result writes and operand/store-data reads. Only one operation is driven per cycle.
- Tracks the 2-cycle read latency and returns tagged read responses.
- Sits between the LSU/FPU/FFU control logic and the register file's ctl_frf_*/dp_frf_data inputs.

Parameters:
- LDQ_DEPTH, 2: entries in the load-write buffer (>=1).
- STARVE_MAX, 4: consecutive cycles a pending FPU-write or read request may lose to the load buffer before it is forced through.
- TAG_W, 2: width of the read request/response tag.

Ports:
- rclk  in  1  clock; all state on posedge.
- arst_l  in  1  asynchronous active-low reset.
- lsu_ld_vld  in  1  load-return write valid; LSU must not assert while ld_buf_full=1.
- lsu_ld_addr  in  7  FRF double-word address.
- lsu_ld_wen  in  2  half write enables ([1]=bits 77:39, [0]=bits 38:0).
- lsu_ld_data  in  78  write data with ECC.
- ld_buf_full  out  1  load buffer holds LDQ_DEPTH entries.
- fpu_wr_req  in  1  FPU write request; held until granted.
- fpu_wr_addr  in  7  write address.
- fpu_wr_wen  in  2  half enables.
- fpu_wr_data  in  78  write data.
- fpu_wr_gnt  out  1  FPU write performed this cycle.
- rd_req  in  1  read request; held until granted.
- rd_addr  in  7  read address.
- rd_tag  in  TAG_W  requester tag.
- rd_gnt  out  1  read issued this cycle.
- frf_dp_data  in  78  FRF registered read data.
- rd_rsp_vld  out  1  read response valid.
- rd_rsp_tag  out  TAG_W  tag of the response.
- rd_rsp_data  out  78  equals frf_dp_data.
- ctl_frf_wen  out  2  to FRF.
- ctl_frf_ren  out  1  to FRF.
- ctl_frf_addr  out  7  to FRF.
- dp_frf_data  out  78  to FRF.

Behaviour:
- Reset (arst_l=0, asynchronous):
  - load buffer emptied; starvation counter cleared; rr_ptr=0 (read favoured); read pipeline cleared.
  - Every output is 0: ld_buf_full, gnt, rsp_vld, rsp_tag, ctl_frf_*, dp_frf_data.
  - Any in-flight read response is dropped; no response appears after reset.
- Port outputs are combinational from the current cycle's selection. When idle, ctl_frf_wen=0, ctl_frf_ren=0, addr=0, data=0.
- Invariant: ctl_frf_ren and any ctl_frf_wen bit are never 1 in the same cycle.
- Load path:
  - If the buffer is empty and lsu_ld_vld=1 and the load wins the port, it bypasses the buffer and is written directly that cycle.
  - Otherwise the load is enqueued.
  - The buffer drains in FIFO order, one entry per cycle it wins.
  - Enqueue and dequeue in the same cycle leave the count unchanged.
- Priority each cycle:
  1. Load (buffer head, or bypass), unless starvation override applies.
  2. FPU write vs read: round-robin.
     - When both request, grant the one not granted last (rr_ptr).
     - rr_ptr updates on every FPU/read grant.
- Starvation counter:
  - Increments each cycle fpu_wr_req|rd_req is pending but the load wins.
  - Clears on any FPU/read grant.
  - Saturates at STARVE_MAX.
  - When counter==STARVE_MAX and buffer count<LDQ_DEPTH, the pending FPU/read request is granted (round-robin among them). A same-cycle lsu_ld_vld is then enqueued.
  - When the buffer is full, the override is suppressed and the load drains.
- ld_buf_full is registered from the next-state count.
- lsu_ld_vld while full is a protocol error: flag it with an assertion; the load is dropped.
- Read latency:
  - Grant in cycle G → rd_rsp_vld=1 in cycle G+2 with rd_rsp_tag=tag captured at G.
  - Tracked by a 2-stage valid/tag shift register.
  - Back-to-back reads produce back-to-back responses.
- No RAW hazard handling is needed: a write granted in cycle N is visible to a read granted in N+1 or later. A read in the same cycle is impossible by arbitration.
- Write data and enables pass through unchanged; wen=2'b00 from a requester is still a granted (no-op) cycle.

Decomposition:
- Package frf_arb_pkg:
  - FRF_ADDR_W=7, FRF_DATA_W=78, FRF_HALF_W=39.
  - Source encoding SRC_NONE/SRC_LD/SRC_FPU/SRC_RD.
  - Load-entry struct {addr, wen, data}.
- Sub-module sparc_ffu_frf_ldq: LDQ_DEPTH FIFO with push/pop/count/full/empty and head outputs. The arbiter instantiates it once.

Test Plan:
- Single read, addr 7'h15, tag 2'b01, no other traffic:
  - Cycle 0: rd_gnt=1, ctl_frf_ren=1, addr=0x15.
  - Cycle 2: rd_rsp_vld=1, tag=01, rd_rsp_data=frf_dp_data.
- fpu_wr_req and rd_req held together for 4 cycles after reset: grants alternate rd, fpu, rd, fpu. wen and ren are never both set.
- lsu_ld_vld with empty buffer concurrent with rd_req: load writes that cycle (wen=lsu_ld_wen); rd_gnt=0; read granted the next cycle.
- lsu_ld_vld every cycle with rd_req held, STARVE_MAX=4:
  - Read is granted in cycle 4.
  - The load arriving in cycle 4 is enqueued (count 1); ld_buf_full stays 0.
- Fill the buffer to 2 while a read is stalled: ld_buf_full=1 the next cycle; no starvation override while full; the buffer drains in order.
- Read granted, then arst_l pulsed low in cycle G+1: rd_rsp_vld stays 0 and all ctl outputs read 0 during and after reset.
